reg_alu_seq: RTL
================

REG_ALU_SEQ -- requirements
Module: reg_alu_seq

Interface
REQ-001 Parameters: none; fixed 8 registers x 16 bits, 2-bit op.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; low clears all state immediately, independent of clk.
REQ-004 instr_valid  input  1  instruction offered this cycle.
REQ-005 instr_ready  output  1  block accepts an instruction this cycle.
REQ-006 instr  input  11  {op[10:9], rd[8:6], rs1[5:3], rs2[2:0]}.
REQ-007 ld_en  input  1  external register load request.
REQ-008 ld_addr  input  3  register loaded when ld_en is honoured.
REQ-009 ld_data  input  16  value loaded when ld_en is honoured.
REQ-010 alu_op  output  2  op to the external ALU; 00 add, 01 sub, 10 and, 11 or.
REQ-011 alu_a, alu_b  output  16 each  ALU operands i0 and i1, registered.
REQ-012 alu_o  input  16  ALU result, combinational from alu_op/alu_a/alu_b.
REQ-013 alu_cout  input  1  ALU carry out; for sub, 1 means no borrow.
REQ-014 res_valid  output  1  one-cycle pulse on writeback.
REQ-015 res_data  output  16  value written back; held until next writeback.
REQ-016 res_cout  output  1  carry flag; updated only on add/sub writeback.
REQ-017 dbg_addr  input  3; dbg_data  output  16  combinational read of register dbg_addr.

Function
REQ-018 FSM states: IDLE, READ, EXEC, WB; one transition per clock, no stalls.
REQ-019 IDLE: instr_ready = 1 unless ld_en = 1; in every other state instr_ready = 0.
REQ-020 Handshake: instruction accepted on a rising edge with IDLE, instr_valid = 1, instr_ready = 1; op/rd/rs1/rs2 latched; IDLE -> READ.
REQ-021 Load: ld_en = 1 in IDLE writes ld_data to ld_addr at that edge; load has priority over a simultaneous instruction, which is not accepted (instr_ready = 0).
REQ-022 ld_en outside IDLE is ignored; no register write and no queueing.
REQ-023 READ: alu_a <= reg[rs1], alu_b <= reg[rs2], alu_op <= latched op; READ -> EXEC.
REQ-024 rs1 = rs2 is legal; both operands receive the same value.
REQ-025 EXEC: alu_o, alu_cout sampled at edge into result registers; EXEC -> WB.
REQ-026 WB: reg[rd] <= captured result; res_valid = 1 for this cycle only; res_data = captured result; WB -> IDLE.
REQ-027 res_cout <= captured cout in WB for op 00/01; unchanged for op 10/11.
REQ-028 rd may equal rs1/rs2; sources read in READ use pre-writeback values.
REQ-029 Latency: accept edge N, res_valid high in cycle N+3, next instruction acceptable at edge N+4; max throughput 1 instruction per 4 cycles.
REQ-030 dbg_data reflects register writes from the edge after the write.
REQ-031 alu_op/alu_a/alu_b hold their values outside READ updates.
REQ-032 All arithmetic width 16; result wraps modulo 2^16; the block performs no arithmetic itself.

Reset
REQ-033 reset low: state = IDLE, all 8 registers = 0, alu_op = 00, alu_a = alu_b = 0, res_data = 0, res_cout = 0, res_valid = 0, instr_ready = 0 while reset low.
REQ-034 reset low mid-instruction aborts it: no writeback, no res_valid; after reset high, first edge is IDLE with instr_ready = 1.

Verification
REQ-035 Load r1 = 0x0005, r2 = 0x0003; add rd = 3 -> res_valid in cycle N+3, res_data = 0x0008, res_cout = 0, dbg r3 = 0x0008.
REQ-036 r1 = 0xFFFF, r2 = 0x0001, add rd = 4 -> res_data = 0x0000, res_cout = 1; then and r1,r2 -> res_data = 0x0001, res_cout stays 1.
REQ-037 r1 = 0x0003, r2 = 0x0005, sub rd = 1 -> res_data = 0xFFFE, res_cout = 0; r1 now 0xFFFE.
REQ-038 ld_en and instr_valid together in IDLE -> load performed, instr_ready = 0, instruction accepted next cycle; ld_en during EXEC -> register unchanged.
REQ-039 Back-to-back instr_valid held high -> acceptances exactly 4 cycles apart; each res_valid exactly one cycle.
REQ-040 reset low during EXEC of or rd = 5 -> r5 = 0, res_valid never asserted, all outputs at reset values.

Source files
------------

// File: rtl/reg_alu_seq.sv
// Sequencer for an 8 x 16-bit register file that drives an external ALU.
// Each instruction steps IDLE -> READ -> EXEC -> WB; loads are taken only in IDLE.
module reg_alu_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [10:0] instr,
    input  logic        ld_en,
    input  logic [2:0]  ld_addr,
    input  logic [15:0] ld_data,
    output logic [1:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_o,
    input  logic        alu_cout,
    output logic        res_valid,
    output logic [15:0] res_data,
    output logic        res_cout,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t      state_q, state_d;
    logic [15:0] regs_q [8];
    logic [15:0] regs_d [8];
    logic [1:0]  op_q, op_d;
    logic [2:0]  rd_q, rd_d;
    logic [2:0]  rs1_q, rs1_d;
    logic [2:0]  rs2_q, rs2_d;
    logic [1:0]  alu_op_q, alu_op_d;
    logic [15:0] alu_a_q, alu_a_d;
    logic [15:0] alu_b_q, alu_b_d;
    logic [15:0] result_q, result_d;
    logic        cout_q, cout_d;
    logic [15:0] res_data_q, res_data_d;
    logic        res_cout_q, res_cout_d;

    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        op_d        = op_q;
        rd_d        = rd_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        result_d    = result_q;
        cout_d      = cout_q;
        res_data_d  = res_data_q;
        res_cout_d  = res_cout_q;
        instr_ready = 1'b0;
        res_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                // A load wins over an offered instruction, which then waits.
                instr_ready = reset & ~ld_en;
                if (ld_en) begin
                    regs_d[ld_addr] = ld_data;
                end else if (instr_valid) begin
                    {op_d, rd_d, rs1_d, rs2_d} = instr;
                    state_d = READ;
                end
            end
            READ: begin
                alu_op_d = op_q;
                alu_a_d  = regs_q[rs1_q];
                alu_b_d  = regs_q[rs2_q];
                state_d  = EXEC;
            end
            EXEC: begin
                result_d = alu_o;
                cout_d   = alu_cout;
                state_d  = WB;
            end
            WB: begin
                regs_d[rd_q] = result_q;
                res_valid    = 1'b1;
                res_data_d   = result_q;
                // Only add (00) and sub (01) produce a meaningful carry.
                if (!op_q[1]) begin
                    res_cout_d = cout_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            regs_q     <= '{default: '0};
            op_q       <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            alu_op_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            res_data_q <= '0;
            res_cout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            regs_q     <= regs_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            alu_op_q   <= alu_op_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            result_q   <= result_d;
            cout_q     <= cout_d;
            res_data_q <= res_data_d;
            res_cout_q <= res_cout_d;
        end
    end

    // During WB the result is presented directly so it lines up with res_valid.
    assign res_data = res_valid ? result_q : res_data_q;
    assign res_cout = (res_valid && !op_q[1]) ? cout_q : res_cout_q;
    assign alu_op   = alu_op_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign dbg_data = regs_q[dbg_addr];

endmodule
